// File: rtl/fcbt_group_feeder.sv
// fcbt_group_feeder: frames a raw element stream into groups for the FCBT accumulator.
//
// Group-length descriptors (desc_*) open a group; elements (data*) are then
// forwarded one per cycle through a single output register (in / valid_in /
// end_of_group) that honours the accumulator's ready. end_of_group marks the
// last element of each group. New groups are throttled so that no more than
// MAX_OUTSTANDING groups are in flight before their acc_valid_out results return.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   desc_valid/ready/len group descriptor channel (legal len 1..MAX_GROUP_SIZE)
//   data_valid/ready/data element channel
//   in, valid_in,        element towards the accumulator; transfer when
//   end_of_group, ready  valid_in && ready
//   acc_valid_out        accumulator result strobe, one per group
//   outstanding          groups issued but not yet answered
//   groups_sent          groups whose last element transferred (wraps)
//   len_err              one-cycle pulse when an illegal descriptor is dropped
module fcbt_group_feeder #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned MAX_GROUP_SIZE  = 128,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned LEN_W           = $clog2(MAX_GROUP_SIZE + 1),
    parameter int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] in,
    output logic             valid_in,
    output logic             end_of_group,
    input  logic             ready,
    input  logic             acc_valid_out,
    output logic [OUT_W-1:0] outstanding,
    output logic [31:0]      groups_sent,
    output logic             len_err
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]   in_q, in_d;
    logic               valid_q, valid_d;
    logic               eog_q, eog_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [31:0]        groups_sent_q, groups_sent_d;
    logic               len_err_q, len_err_d;

    logic               len_ok;
    logic               xfer;
    logic               inc;

    assign len_ok = (desc_len != '0) && (desc_len <= LEN_W'(MAX_GROUP_SIZE));
    assign xfer   = valid_q && ready;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        in_d          = in_q;
        valid_d       = valid_q;
        eog_d         = eog_q;
        groups_sent_d = groups_sent_q;
        outstanding_d = outstanding_q;
        len_err_d     = 1'b0;
        desc_ready    = 1'b0;
        data_ready    = 1'b0;
        inc           = 1'b0;

        if (xfer && eog_q) begin
            groups_sent_d = groups_sent_q + 32'd1;
        end
        // Drain the output register; a same-cycle load below overrides this.
        if (xfer) begin
            valid_d = 1'b0;
            eog_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Gated by rst_n so the handshake is quiet while reset is held.
                desc_ready = rst_n && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
                if (desc_valid && desc_ready) begin
                    if (len_ok) begin
                        remaining_d = desc_len;
                        inc         = 1'b1;
                        state_d     = StStream;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StStream: begin
                data_ready = !valid_q || ready;
                if (data_valid && data_ready) begin
                    in_d        = data;
                    valid_d     = 1'b1;
                    eog_d       = (remaining_q == LEN_W'(1));
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Simultaneous issue and result leave the count unchanged; saturate at zero.
        if (inc && !acc_valid_out) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!inc && acc_valid_out && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            in_q          <= '0;
            valid_q       <= 1'b0;
            eog_q         <= 1'b0;
            outstanding_q <= '0;
            groups_sent_q <= '0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            in_q          <= in_d;
            valid_q       <= valid_d;
            eog_q         <= eog_d;
            outstanding_q <= outstanding_d;
            groups_sent_q <= groups_sent_d;
            len_err_q     <= len_err_d;
        end
    end

    assign in           = in_q;
    assign valid_in     = valid_q;
    assign end_of_group = eog_q;
    assign outstanding  = outstanding_q;
    assign groups_sent  = groups_sent_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_fcbt_group_feeder.sv
// Bench for fcbt_group_feeder: directed scenarios plus randomized traffic, with a
// behavioural model of the feeder checked against the DUT on every cycle.
module tb_fcbt_group_feeder;

    localparam int W  = 32;
    localparam int MG = 128;
    localparam int MO = 4;
    localparam int LW = 8;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          desc_valid, desc_ready;
    logic [LW-1:0] desc_len;
    logic          data_valid, data_ready;
    logic [W-1:0]  data;
    logic [W-1:0]  acc_in;
    logic          valid_in, end_of_group, ready, acc_valid_out;
    logic [OW-1:0] outstanding;
    logic [31:0]   groups_sent;
    logic          len_err;

    always #5 clk = ~clk;

    fcbt_group_feeder #(
        .WIDTH          (W),
        .MAX_GROUP_SIZE (MG),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .desc_len     (desc_len),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data         (data),
        .in           (acc_in),
        .valid_in     (valid_in),
        .end_of_group (end_of_group),
        .ready        (ready),
        .acc_valid_out(acc_valid_out),
        .outstanding  (outstanding),
        .groups_sent  (groups_sent),
        .len_err      (len_err)
    );

    int total = 0;
    int bad   = 0;

    // Model: elements still owed to the open group, groups in flight, and the
    // element currently offered to the accumulator.
    int          m_left, m_out;
    logic [31:0] m_gs;
    logic        m_lerr, m_v, m_eog;
    logic [31:0] m_in;

    typedef struct {logic [31:0] d; logic e;} xfer_t;
    xfer_t xq[$];

    logic desc_hs, data_hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_left = 0; m_out = 0; m_gs = '0; m_lerr = 1'b0;
        m_v = 1'b0; m_eog = 1'b0; m_in = '0;
    endfunction

    // Compare the DUT against the model, then advance one clock.
    task automatic step();
        logic          exp_dr, exp_dar, s_rdy, s_acc;
        logic [LW-1:0] s_len;
        logic [31:0]   s_data;
        xfer_t         t;
        bit            legal, inc;
        #1;
        exp_dr  = rst_n && (m_left == 0) && (m_out < MO);
        exp_dar = rst_n && (m_left > 0) && (!m_v || ready);
        chk("desc_ready", desc_ready, exp_dr);
        chk("data_ready", data_ready, exp_dar);
        chk("valid_in", valid_in, m_v);
        chk("end_of_group", end_of_group, m_eog);
        if (m_v) chk("in", acc_in, m_in);
        chk("outstanding", outstanding, m_out);
        chk("groups_sent", groups_sent, m_gs);
        chk("len_err", len_err, m_lerr);
        if (valid_in && ready) begin
            t.d = acc_in; t.e = end_of_group; xq.push_back(t);
        end
        desc_hs = desc_valid && exp_dr;
        data_hs = data_valid && exp_dar;
        s_len = desc_len; s_data = data; s_rdy = ready; s_acc = acc_valid_out;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            legal  = (s_len >= 1) && (s_len <= MG);
            inc    = desc_hs && legal;
            m_lerr = desc_hs && !legal;
            if (inc && !s_acc) m_out++;
            else if (!inc && s_acc && m_out > 0) m_out--;
            if (m_v && s_rdy && m_eog) m_gs++;
            if (data_hs) begin
                m_in = s_data; m_v = 1'b1; m_eog = (m_left == 1); m_left--;
            end else if (m_v && s_rdy) begin
                m_v = 1'b0; m_eog = 1'b0;
            end
            if (inc) m_left = int'(s_len);
        end
        @(negedge clk);
    endtask

    task automatic put_desc(input int len, output int waited);
        desc_valid = 1'b1; desc_len = LW'(len); waited = 0;
        do begin step(); waited++; end while (!desc_hs && waited < 300);
        if (!desc_hs) chk("desc_timeout", 0, 1);
        desc_valid = 1'b0;
    endtask

    task automatic put_data(input logic [31:0] v, output int waited);
        data_valid = 1'b1; data = v; waited = 0;
        do begin step(); waited++; end while (!data_hs && waited < 300);
        if (!data_hs) chk("data_timeout", 0, 1);
        data_valid = 1'b0;
    endtask

    task automatic send_group(input int len, input logic [31:0] base);
        int w;
        put_desc(len, w);
        for (int i = 0; i < len; i++) put_data(base + 32'(i), w);
    endtask

    task automatic acc_pulse();
        acc_valid_out = 1'b1; step(); acc_valid_out = 1'b0;
    endtask

    initial begin
        int w;
        rst_n = 1'b0; desc_valid = 1'b0; desc_len = '0; data_valid = 1'b0;
        data = '0; ready = 1'b1; acc_valid_out = 1'b0;
        model_reset();
        @(negedge clk); #1;
        chk("rst_valid_in", valid_in, 0);
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_groups_sent", groups_sent, 0);
        rst_n = 1'b1;

        // Three-element group at full rate.
        xq.delete();
        put_desc(3, w);
        chk("t1_desc_wait", w, 1);
        put_data(32'h3f80_0000, w); chk("t1_d0_wait", w, 1);
        put_data(32'h4000_0000, w); chk("t1_d1_wait", w, 1);
        put_data(32'h4040_0000, w); chk("t1_d2_wait", w, 1);
        step(); step();
        chk("t1_count", xq.size(), 3);
        if (xq.size() == 3) begin
            chk("t1_x0", {xq[0].e, xq[0].d}, {1'b0, 32'h3f80_0000});
            chk("t1_x1", {xq[1].e, xq[1].d}, {1'b0, 32'h4000_0000});
            chk("t1_x2", {xq[2].e, xq[2].d}, {1'b1, 32'h4040_0000});
        end
        chk("t1_groups_sent", groups_sent, 1);
        chk("t1_outstanding", outstanding, 1);
        acc_pulse();
        chk("t1_outstanding_ret", outstanding, 0);

        // Single-element group.
        xq.delete();
        send_group(1, 32'h40a0_0000);
        step(); step();
        chk("t2_count", xq.size(), 1);
        if (xq.size() == 1) chk("t2_x0", {xq[0].e, xq[0].d}, {1'b1, 32'h40a0_0000});
        acc_pulse();

        // Backpressure on element 2 of a four-element group.
        xq.delete();
        put_desc(4, w);
        put_data(32'hA, w); put_data(32'hB, w);
        ready = 1'b0; data_valid = 1'b1; data = 32'hC;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t3_stall_in", acc_in, 32'hB);
            chk("t3_stall_eog", end_of_group, 0);
            chk("t3_stall_dready", data_ready, 0);
        end
        ready = 1'b1;
        put_data(32'hC, w); put_data(32'hD, w);
        step(); step();
        chk("t3_count", xq.size(), 4);
        if (xq.size() == 4) begin
            chk("t3_x0", {xq[0].e, xq[0].d}, {1'b0, 32'hA});
            chk("t3_x1", {xq[1].e, xq[1].d}, {1'b0, 32'hB});
            chk("t3_x2", {xq[2].e, xq[2].d}, {1'b0, 32'hC});
            chk("t3_x3", {xq[3].e, xq[3].d}, {1'b1, 32'hD});
        end
        acc_pulse();

        // Outstanding limit.
        for (int g = 0; g < 4; g++) send_group(2, 32'h100 * 32'(g));
        step();
        chk("t4_out_full", outstanding, 4);
        desc_valid = 1'b1; desc_len = LW'(2);
        step(); step();
        chk("t4_blocked", desc_ready, 0);
        acc_pulse();
        chk("t4_out_after_ret", outstanding, 3);
        chk("t4_unblocked", desc_ready, 1);
        acc_valid_out = 1'b1; step(); acc_valid_out = 1'b0;
        chk("t4_accept_hs", desc_hs, 1);
        desc_valid = 1'b0;
        chk("t4_out_simul", outstanding, 3);
        put_data(32'h500, w); put_data(32'h501, w);
        acc_valid_out = 1'b1;
        for (int i = 0; i < 5; i++) step();
        acc_valid_out = 1'b0;
        chk("t4_out_drain", outstanding, 0);

        // Illegal lengths.
        put_desc(0, w);
        chk("t5_lerr0", len_err, 1);
        step();
        chk("t5_lerr0_off", len_err, 0);
        put_desc(MG + 1, w);
        chk("t5_lerr129", len_err, 1);
        chk("t5_no_valid", valid_in, 0);
        chk("t5_out", outstanding, 0);
        xq.delete();
        send_group(2, 32'h77);
        step(); step();
        chk("t5_count", xq.size(), 2);
        if (xq.size() == 2) chk("t5_x1", {xq[1].e, xq[1].d}, {1'b1, 32'h78});
        acc_pulse();

        // Reset in the middle of a group with an element pending.
        put_desc(5, w);
        put_data(32'h11, w); put_data(32'h22, w);
        ready = 1'b0;
        rst_n = 1'b0; #1;
        chk("t6_rst_valid", valid_in, 0);
        chk("t6_rst_in", acc_in, 0);
        chk("t6_rst_eog", end_of_group, 0);
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_gs", groups_sent, 0);
        chk("t6_rst_dready", data_ready, 0);
        model_reset();
        step();
        rst_n = 1'b1; ready = 1'b1;
        xq.delete();
        send_group(2, 32'h33);
        step(); step();
        chk("t6_count", xq.size(), 2);
        if (xq.size() == 2) begin
            chk("t6_x0", {xq[0].e, xq[0].d}, {1'b0, 32'h33});
            chk("t6_x1", {xq[1].e, xq[1].d}, {1'b1, 32'h34});
        end
        chk("t6_gs", groups_sent, 1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            desc_valid = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 9))
                0:       desc_len = LW'(0);
                1:       desc_len = LW'(MG + 1);
                2:       desc_len = LW'(200);
                3:       desc_len = LW'(MG);
                default: desc_len = LW'($urandom_range(1, 6));
            endcase
            data_valid    = ($urandom_range(0, 99) < 60);
            data          = $urandom;
            ready         = ($urandom_range(0, 99) < 70);
            acc_valid_out = ($urandom_range(0, 99) < 15);
            step();
        end
        desc_valid = 1'b0; data_valid = 1'b0; ready = 1'b1; acc_valid_out = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
